// File: rtl/riscv_lsu_if.sv
// riscv_lsu_if: request/response handshake toward the core plus the
// word-wide data RAM port of the load/store unit.
// slave modport is the LSU side; master is the core + RAM side.
interface riscv_lsu_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid_in;
    logic              req_ready_out;
    logic              req_we_in;
    logic [2:0]        req_size_in;
    logic [31:0]       req_addr_in;
    logic [31:0]       req_wdata_in;
    logic              resp_valid_out;
    logic [31:0]       resp_rdata_out;
    logic              resp_err_out;
    logic [ADDR_W-1:0] ram_addr_out;
    logic              ram_we_out;
    logic [31:0]       ram_wdata_out;
    logic [31:0]       ram_rdata_in;

    modport slave (
        input  req_valid_in, req_we_in, req_size_in, req_addr_in, req_wdata_in,
        input  ram_rdata_in,
        output req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
        output ram_addr_out, ram_we_out, ram_wdata_out
    );

    modport master (
        output req_valid_in, req_we_in, req_size_in, req_addr_in, req_wdata_in,
        output ram_rdata_in,
        input  req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
        input  ram_addr_out, ram_we_out, ram_wdata_out
    );
endinterface

// File: rtl/riscv_lsu.sv
// riscv_lsu: byte/half/word load-store unit in front of a single-port,
// word-wide RAM with 2-cycle read latency and no byte enables.
// Sub-word stores are done as read-modify-write.
// Optional feature: define RISCV_LSU_MISALIGN_EN to reject misaligned
// halfword/word accesses with an error instead of ignoring offset bits.
module riscv_lsu #(
    parameter int ADDR_W = 14
) (
    input logic       clk_100mhz,
    input logic       rst_in,
    riscv_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD1, RD2, RD3} state_t;

    state_t            state, state_next;
    logic              we_q;
    logic [2:0]        size_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic              ready, accept, size_ok, misalign, req_err, is_sw;
    logic [ADDR_W-1:0] word_idx;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_data, merge_data;
    logic              resp_valid, resp_err, ram_we;
    logic [31:0]       resp_rdata, ram_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              unused_addr_bits;

    assign ready    = (state == IDLE) && !rst_in;
    assign accept   = bus.req_valid_in && ready;
    assign word_idx = bus.req_addr_in[ADDR_W+1:2];
    assign is_sw    = bus.req_we_in && (bus.req_size_in == 3'b010);
    assign req_err  = !size_ok || misalign;
    assign unused_addr_bits = ^bus.req_addr_in[31:ADDR_W+2];

    assign bus.req_ready_out  = ready;
    assign bus.resp_valid_out = resp_valid;
    assign bus.resp_err_out   = resp_err;
    assign bus.resp_rdata_out = resp_rdata;
    assign bus.ram_addr_out   = ram_addr;
    assign bus.ram_we_out     = ram_we;
    assign bus.ram_wdata_out  = ram_wdata;

    // Classify the incoming request: legal size for its direction, and alignment when checked
    always_comb begin
        size_ok  = 1'b0;
        misalign = 1'b0;
        case (bus.req_size_in)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !bus.req_we_in;
            default:                size_ok = 1'b0;
        endcase
`ifdef RISCV_LSU_MISALIGN_EN
        if (bus.req_size_in[1:0] == 2'b01 && bus.req_addr_in[0])
            misalign = 1'b1;
        if (bus.req_size_in == 3'b010 && bus.req_addr_in[1:0] != 2'b00)
            misalign = 1'b1;
`endif
    end

    // Lane selection, load extension and store merge from the RAM word in RD3
    always_comb begin
        byte_sel   = 8'h00;
        half_sel   = lane_q[1] ? bus.ram_rdata_in[31:16] : bus.ram_rdata_in[15:0];
        load_data  = bus.ram_rdata_in;
        merge_data = bus.ram_rdata_in;
        case (lane_q)
            2'd0:    byte_sel = bus.ram_rdata_in[7:0];
            2'd1:    byte_sel = bus.ram_rdata_in[15:8];
            2'd2:    byte_sel = bus.ram_rdata_in[23:16];
            default: byte_sel = bus.ram_rdata_in[31:24];
        endcase
        case (size_q[1:0])
            2'b00: begin
                load_data = {{24{byte_sel[7] & ~size_q[2]}}, byte_sel};
                case (lane_q)
                    2'd0:    merge_data[7:0]   = wdata_q[7:0];
                    2'd1:    merge_data[15:8]  = wdata_q[7:0];
                    2'd2:    merge_data[23:16] = wdata_q[7:0];
                    default: merge_data[31:24] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                load_data = {{16{half_sel[15] & ~size_q[2]}}, half_sel};
                if (lane_q[1])
                    merge_data[31:16] = wdata_q;
                else
                    merge_data[15:0] = wdata_q;
            end
            default: load_data = bus.ram_rdata_in;
        endcase
    end

    // Next-state: only loads and sub-word stores walk the read pipeline
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !req_err && !is_sw) state_next = RD1;
            RD1:     state_next = RD2;
            RD2:     state_next = RD3;
            RD3:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_100mhz) begin
        if (rst_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Registered RAM port, request latches and response outputs
    always_ff @(posedge clk_100mhz) begin
        if (rst_in) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            ram_addr   <= '0;
            ram_we     <= 1'b0;
            ram_wdata  <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= 3'b000;
            lane_q     <= 2'b00;
            wdata_q    <= 16'h0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            ram_we     <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else if (is_sw) begin
                            ram_addr   <= word_idx;
                            ram_we     <= 1'b1;
                            ram_wdata  <= bus.req_wdata_in;
                            resp_valid <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            ram_addr <= word_idx;
                            we_q     <= bus.req_we_in;
                            size_q   <= bus.req_size_in;
                            lane_q   <= bus.req_addr_in[1:0];
                            wdata_q  <= bus.req_wdata_in[15:0];
                        end
                    end
                end
                RD3: begin
                    resp_valid <= 1'b1;
                    if (we_q) begin
                        ram_wdata  <= merge_data;
                        ram_we     <= 1'b1;
                        resp_rdata <= 32'h0;
                    end else begin
                        resp_rdata <= load_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: scoreboard bench for riscv_lsu with a 2-cycle-latency RAM model.
// Honours RISCV_LSU_MISALIGN_EN in its reference model.
module tb_riscv_lsu;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic        clk;
    logic        rst;
    int          cyc;
    int          testCount;
    int          failCount;
    resp_t       respQ[$];
    wr_t         wrQ[$];
    resp_t       monResp;
    wr_t         monWr;
    logic [31:0] memModel [0:16383];
    logic [31:0] ram      [0:16383];
    logic [31:0] rd1, rd2;
    logic [31:0] saved;

    riscv_lsu_if #(.ADDR_W(14)) bus ();

    riscv_lsu #(.ADDR_W(14)) dut (
        .clk_100mhz (clk),
        .rst_in     (rst),
        .bus        (bus.slave)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time responses and writes
    always @(posedge clk) cyc <= cyc + 1;

    // Data RAM model: full-word write, read data appears two cycles after its address
    always @(posedge clk) begin
        if (bus.ram_we_out)
            ram[bus.ram_addr_out] <= bus.ram_wdata_out;
        rd1 <= ram[bus.ram_addr_out];
        rd2 <= rd1;
    end
    assign bus.ram_rdata_in = rd2;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every RAM write and every response must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.ram_we_out) begin
                if (wrQ.size() == 0) begin
                    checkOutput("unexpected_we", 32'd1, 32'd0);
                end else begin
                    monWr = wrQ.pop_front();
                    checkOutput("wr_addr", {18'h0, bus.ram_addr_out}, {18'h0, monWr.addr});
                    checkOutput("wr_data", bus.ram_wdata_out, monWr.data);
                    checkOutput("wr_cycle", cyc, monWr.cyc);
                end
            end
            if (bus.resp_valid_out) begin
                if (respQ.size() == 0) begin
                    checkOutput("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    monResp = respQ.pop_front();
                    checkOutput("resp_rdata", bus.resp_rdata_out, monResp.rdata);
                    checkOutput("resp_err", {31'h0, bus.resp_err_out}, {31'h0, monResp.err});
                    checkOutput("resp_cycle", cyc, monResp.cyc);
                end
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int          waited;
        int          c;
        logic [13:0] idx;
        logic [1:0]  lane;
        logic [31:0] w;
        logic [31:0] val;
        logic [7:0]  b;
        logic [15:0] h;
        bit          bad;
        resp_t       r;
        wr_t         wr;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready_out && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready_out) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            return;
        end
        bus.req_valid_in = 1'b1;
        bus.req_we_in    = we;
        bus.req_size_in  = size;
        bus.req_addr_in  = addr;
        bus.req_wdata_in = wdata;
        c    = cyc;
        idx  = addr[15:2];
        lane = addr[1:0];
        w    = memModel[idx];
        b    = 8'(w >> (8 * lane));
        h    = addr[1] ? w[31:16] : w[15:0];
        bad  = 1'b0;
        if (we && !(size inside {3'b000, 3'b001, 3'b010})) bad = 1'b1;
        if (!we && (size inside {3'b011, 3'b110, 3'b111})) bad = 1'b1;
`ifdef RISCV_LSU_MISALIGN_EN
        if ((size == 3'b001 || size == 3'b101) && addr[0]) bad = 1'b1;
        if (size == 3'b010 && addr[1:0] != 2'b00) bad = 1'b1;
`endif
        if (bad) begin
            r = '{32'h0, 1'b1, c + 1};
            respQ.push_back(r);
        end else if (we && size == 3'b010) begin
            memModel[idx] = wdata;
            wr = '{idx, wdata, c + 1};
            wrQ.push_back(wr);
            r = '{32'h0, 1'b0, c + 1};
            respQ.push_back(r);
        end else if (we) begin
            val = w;
            if (size == 3'b000) begin
                case (lane)
                    2'd0:    val[7:0]   = wdata[7:0];
                    2'd1:    val[15:8]  = wdata[7:0];
                    2'd2:    val[23:16] = wdata[7:0];
                    default: val[31:24] = wdata[7:0];
                endcase
            end else if (addr[1]) begin
                val[31:16] = wdata[15:0];
            end else begin
                val[15:0] = wdata[15:0];
            end
            memModel[idx] = val;
            wr = '{idx, val, c + 4};
            wrQ.push_back(wr);
            r = '{32'h0, 1'b0, c + 4};
            respQ.push_back(r);
        end else begin
            case (size)
                3'b000:  val = {{24{b[7]}}, b};
                3'b100:  val = {24'h0, b};
                3'b001:  val = {{16{h[15]}}, h};
                3'b101:  val = {16'h0, h};
                default: val = w;
            endcase
            r = '{val, 1'b0, c + 4};
            respQ.push_back(r);
        end
        @(posedge clk);
        #1;
        bus.req_valid_in = 1'b0;
        bus.req_we_in    = 1'($urandom_range(0, 1));
        bus.req_size_in  = 3'($urandom_range(0, 7));
        bus.req_addr_in  = $urandom;
        bus.req_wdata_in = $urandom;
    endtask

    initial begin
        cyc = 0;
        testCount = 0;
        failCount = 0;
        rd1 = 32'h0;
        rd2 = 32'h0;
        for (int i = 0; i < 16384; i++) begin
            memModel[i] = 32'h0;
            ram[i]      = 32'h0;
        end
        rst              = 1'b1;
        bus.req_valid_in = 1'b0;
        bus.req_we_in    = 1'b0;
        bus.req_size_in  = 3'b000;
        bus.req_addr_in  = 32'h0;
        bus.req_wdata_in = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("ready_in_reset", {31'h0, bus.req_ready_out}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'h0, bus.req_ready_out}, 32'd1);
        checkOutput("rst_resp_valid", {31'h0, bus.resp_valid_out}, 32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata_out, 32'h0);
        checkOutput("rst_resp_err", {31'h0, bus.resp_err_out}, 32'd0);
        checkOutput("rst_ram_addr", {18'h0, bus.ram_addr_out}, 32'h0);
        checkOutput("rst_ram_we", {31'h0, bus.ram_we_out}, 32'd0);
        checkOutput("rst_ram_wdata", bus.ram_wdata_out, 32'h0);

        // word store and load back
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);

        // sign / zero extension
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h80817F01);
        applyStimulus(1'b0, 3'b000, 32'h13, 32'h0);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0);
        applyStimulus(1'b0, 3'b101, 32'h10, 32'h0);
        applyStimulus(1'b0, 3'b100, 32'h11, 32'h0);

        // sub-word read-modify-write with ready low through the read
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h11223344);
        applyStimulus(1'b1, 3'b000, 32'h11, 32'h000000AA);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checkOutput("ready_low_rmw", {31'h0, bus.req_ready_out}, 32'd0);
        end
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h11223344);
        applyStimulus(1'b1, 3'b001, 32'h12, 32'h0000BEEF);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);

        // misaligned word load, invalid sizes, address wrap
        applyStimulus(1'b0, 3'b010, 32'h12, 32'h0);
        applyStimulus(1'b0, 3'b001, 32'h11, 32'h0);
        applyStimulus(1'b0, 3'b011, 32'h10, 32'h0);
        applyStimulus(1'b1, 3'b100, 32'h10, 32'h12345678);
        applyStimulus(1'b0, 3'b010, 32'h0001_0010, 32'h0);

        // back-to-back word stores, then read them back
        applyStimulus(1'b1, 3'b010, 32'h20, 32'hA0A0A0A0);
        applyStimulus(1'b1, 3'b010, 32'h24, 32'hB1B1B1B1);
        applyStimulus(1'b1, 3'b010, 32'h28, 32'hC2C2C2C2);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h24, 32'h0);
        applyStimulus(1'b0, 3'b010, 32'h28, 32'h0);

        // reset during RD2 of a byte store drops the write and the response
        saved = memModel[4];
        applyStimulus(1'b1, 3'b000, 32'h11, 32'h00000055);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        respQ.delete();
        wrQ.delete();
        memModel[4] = saved;
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", {31'h0, bus.req_ready_out}, 32'd1);
        repeat (6) @(negedge clk);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0);

        // random mix over a small window
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          32'h40 + 32'($urandom_range(0, 31)), $urandom);
        end

        for (int i = 0; i < 20 && (respQ.size() != 0 || wrQ.size() != 0); i++)
            @(negedge clk);
        checkOutput("resp_pending", respQ.size(), 32'd0);
        checkOutput("wr_pending", wrQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
